// File: rtl/match_pkg.sv
// Shared types and defaults for the two-player match round controller.
package match_pkg;

   typedef enum logic [1:0] {
      PLAY    = 2'd0,
      AWARD   = 2'd1,
      RESTART = 2'd2,
      DONE    = 2'd3
   } matchState_t;

   localparam logic VICTOR_LEFT  = 1'b0;
   localparam logic VICTOR_RIGHT = 1'b1;

   localparam int DEFAULT_SCORE_W     = 3;
   localparam int DEFAULT_WIN_SCORE   = 7;
   localparam int DEFAULT_HOLD_CYCLES = 4;

endpackage

// File: rtl/player_score_counter.sv
// Per-player score register: synchronous clear, +1 on Inc.
module player_score_counter #(
   parameter int SCORE_W = 3
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Inc,
   output logic [SCORE_W-1:0] Score
);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         Score <= '0;
      end else if (Inc) begin
         Score <= Score + SCORE_W'(1);
      end
   end

endmodule

// File: rtl/match_round_controller.sv
// Round sequencer: edge-detects round wins, breaks ties round-robin,
// awards points, pulses the playfield restart and freezes on match victory.
module match_round_controller
   import match_pkg::*;
#(
   parameter int SCORE_W     = DEFAULT_SCORE_W,
   parameter int WIN_SCORE   = DEFAULT_WIN_SCORE,
   parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               LeftWin,
   input  logic               RightWin,
   output logic [SCORE_W-1:0] LeftScore,
   output logic [SCORE_W-1:0] RightScore,
   output logic               RoundReset,
   output logic               MatchOver,
   output logic               Victor
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [SCORE_W:0]   WIN_VAL   = (SCORE_W + 1)'(WIN_SCORE);

   matchState_t       state;
   matchState_t       stateNext;
   logic              prevL;
   logic              prevR;
   logic              reqL;
   logic              reqR;
   logic              tiePtr;
   logic              tiePtrNext;
   logic              grant;
   logic              grantNext;
   logic [HOLD_W-1:0] holdCnt;
   logic [HOLD_W-1:0] holdCntNext;
   logic              roundResetNext;
   logic              matchOverNext;
   logic              victorNext;
   logic              incLeft;
   logic              incRight;
   logic [SCORE_W:0]  grantedSum;
   logic              awardWins;

   assign reqL = LeftWin  & ~prevL;
   assign reqR = RightWin & ~prevR;

   // One extra bit on the sum so the win compare never sees a wrapped value.
   assign grantedSum = (grant ? {1'b0, RightScore} : {1'b0, LeftScore}) + (SCORE_W + 1)'(1);
   assign awardWins  = (grantedSum == WIN_VAL);

   assign incLeft  = (state == AWARD) && (grant == VICTOR_LEFT);
   assign incRight = (state == AWARD) && (grant == VICTOR_RIGHT);

   player_score_counter #(.SCORE_W(SCORE_W)) leftCounter (
      .Clock (Clock),
      .Reset (Reset),
      .Inc   (incLeft),
      .Score (LeftScore)
   );

   player_score_counter #(.SCORE_W(SCORE_W)) rightCounter (
      .Clock (Clock),
      .Reset (Reset),
      .Inc   (incRight),
      .Score (RightScore)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= PLAY;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         PLAY:    if (reqL || reqR) stateNext = AWARD;
         AWARD:   stateNext = awardWins ? DONE : RESTART;
         RESTART: if (holdCnt == '0) stateNext = PLAY;
         DONE:    stateNext = DONE;
         default: stateNext = PLAY;
      endcase
   end

   // Requests seen outside PLAY fall through here untouched, so they are dropped.
   always_comb begin
      tiePtrNext     = tiePtr;
      grantNext      = grant;
      holdCntNext    = holdCnt;
      roundResetNext = RoundReset;
      matchOverNext  = MatchOver;
      victorNext     = Victor;
      case (state)
         PLAY: begin
            if (reqL && reqR) begin
               grantNext  = tiePtr;
               tiePtrNext = ~tiePtr;
            end else if (reqL) begin
               grantNext = VICTOR_LEFT;
            end else if (reqR) begin
               grantNext = VICTOR_RIGHT;
            end
         end
         AWARD: begin
            if (awardWins) begin
               matchOverNext = 1'b1;
               victorNext    = grant ? VICTOR_RIGHT : VICTOR_LEFT;
            end else begin
               roundResetNext = 1'b1;
               holdCntNext    = HOLD_LOAD;
            end
         end
         RESTART: begin
            if (holdCnt == '0) begin
               roundResetNext = 1'b0;
            end else begin
               holdCntNext = holdCnt - HOLD_W'(1);
            end
         end
         DONE: begin
            roundResetNext = 1'b0;
         end
         default: begin
            roundResetNext = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         prevL      <= 1'b0;
         prevR      <= 1'b0;
         tiePtr     <= 1'b0;
         grant      <= 1'b0;
         holdCnt    <= '0;
         RoundReset <= 1'b0;
         MatchOver  <= 1'b0;
         Victor     <= VICTOR_LEFT;
      end else begin
         prevL      <= LeftWin;
         prevR      <= RightWin;
         tiePtr     <= tiePtrNext;
         grant      <= grantNext;
         holdCnt    <= holdCntNext;
         RoundReset <= roundResetNext;
         MatchOver  <= matchOverNext;
         Victor     <= victorNext;
      end
   end

endmodule

// File: tb/tb_match_round_controller.sv
// Directed bench for match_round_controller: default configuration plus a
// WIN_SCORE=1 / HOLD_CYCLES=1 instance.
module tb_match_round_controller;
   import match_pkg::*;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       LeftWin;
   logic       RightWin;
   logic [2:0] LeftScore;
   logic [2:0] RightScore;
   logic       RoundReset;
   logic       MatchOver;
   logic       Victor;

   logic       resetSmall;
   logic       leftWinSmall;
   logic       rightWinSmall;
   logic [2:0] leftScoreSmall;
   logic [2:0] rightScoreSmall;
   logic       roundResetSmall;
   logic       matchOverSmall;
   logic       victorSmall;

   int checkCount = 0;
   int failCount  = 0;
   int rrHigh;

   always #5 Clock = ~Clock;

   match_round_controller #(.SCORE_W(3), .WIN_SCORE(7), .HOLD_CYCLES(4)) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .LeftWin    (LeftWin),
      .RightWin   (RightWin),
      .LeftScore  (LeftScore),
      .RightScore (RightScore),
      .RoundReset (RoundReset),
      .MatchOver  (MatchOver),
      .Victor     (Victor)
   );

   match_round_controller #(.SCORE_W(3), .WIN_SCORE(1), .HOLD_CYCLES(1)) dutSmall (
      .Clock      (Clock),
      .Reset      (resetSmall),
      .LeftWin    (leftWinSmall),
      .RightWin   (rightWinSmall),
      .LeftScore  (leftScoreSmall),
      .RightScore (rightScoreSmall),
      .RoundReset (roundResetSmall),
      .MatchOver  (matchOverSmall),
      .Victor     (victorSmall)
   );

   task automatic doReset();
      @(negedge Clock);
      Reset = 1'b1; LeftWin = 1'b0; RightWin = 1'b0;
      @(negedge Clock);
      Reset = 1'b0;
   endtask

   // One-cycle win pulse followed by enough cycles to finish the restart.
   task automatic winRound(input bit right);
      if (right) RightWin = 1'b1; else LeftWin = 1'b1;
      @(negedge Clock);
      LeftWin = 1'b0; RightWin = 1'b0;
      repeat (6) @(negedge Clock);
   endtask

   task automatic test_reset();
      Reset = 1'b1; LeftWin = 1'b0; RightWin = 1'b0;
      resetSmall = 1'b1; leftWinSmall = 1'b0; rightWinSmall = 1'b0;
      repeat (2) @(negedge Clock);
      Reset = 1'b0; resetSmall = 1'b0;
      checkCount++; if (LeftScore !== 3'd0) begin failCount++; $display("[TB] FAIL reset_left_score actual=%0d required=0", LeftScore); end
      checkCount++; if (RightScore !== 3'd0) begin failCount++; $display("[TB] FAIL reset_right_score actual=%0d required=0", RightScore); end
      checkCount++; if (RoundReset !== 1'b0) begin failCount++; $display("[TB] FAIL reset_round_reset actual=%b required=0", RoundReset); end
      checkCount++; if (MatchOver !== 1'b0) begin failCount++; $display("[TB] FAIL reset_match_over actual=%b required=0", MatchOver); end
      checkCount++; if (Victor !== 1'b0) begin failCount++; $display("[TB] FAIL reset_victor actual=%b required=0", Victor); end
      checkCount++; if (dut.state !== PLAY) begin failCount++; $display("[TB] FAIL reset_state actual=%0d required=%0d", dut.state, PLAY); end
      checkCount++; if (matchOverSmall !== 1'b0) begin failCount++; $display("[TB] FAIL reset_small_match_over actual=%b required=0", matchOverSmall); end
   endtask

   task automatic test_single_left();
      doReset();
      LeftWin = 1'b1;
      @(negedge Clock);
      checkCount++; if (dut.state !== AWARD) begin failCount++; $display("[TB] FAIL single_award_state actual=%0d required=%0d", dut.state, AWARD); end
      checkCount++; if (LeftScore !== 3'd0) begin failCount++; $display("[TB] FAIL single_score_before actual=%0d required=0", LeftScore); end
      @(negedge Clock);
      checkCount++; if (LeftScore !== 3'd1) begin failCount++; $display("[TB] FAIL single_score_after actual=%0d required=1", LeftScore); end
      rrHigh = RoundReset ? 1 : 0;
      repeat (8) begin
         @(negedge Clock);
         if (RoundReset) rrHigh++;
      end
      checkCount++; if (rrHigh != 4) begin failCount++; $display("[TB] FAIL single_round_reset_len actual=%0d required=4", rrHigh); end
      checkCount++; if (LeftScore !== 3'd1) begin failCount++; $display("[TB] FAIL single_held_no_repeat actual=%0d required=1", LeftScore); end
      checkCount++; if (dut.state !== PLAY) begin failCount++; $display("[TB] FAIL single_back_to_play actual=%0d required=%0d", dut.state, PLAY); end
      LeftWin = 1'b0;
      @(negedge Clock);
   endtask

   task automatic test_tie();
      doReset();
      LeftWin = 1'b1; RightWin = 1'b1;
      repeat (2) @(negedge Clock);
      checkCount++; if (LeftScore !== 3'd1 || RightScore !== 3'd0) begin failCount++; $display("[TB] FAIL tie1_scores actual=%0d/%0d required=1/0", LeftScore, RightScore); end
      checkCount++; if (dut.tiePtr !== 1'b1) begin failCount++; $display("[TB] FAIL tie1_pointer actual=%b required=1", dut.tiePtr); end
      LeftWin = 1'b0; RightWin = 1'b0;
      repeat (6) @(negedge Clock);
      LeftWin = 1'b1; RightWin = 1'b1;
      repeat (2) @(negedge Clock);
      checkCount++; if (LeftScore !== 3'd1 || RightScore !== 3'd1) begin failCount++; $display("[TB] FAIL tie2_scores actual=%0d/%0d required=1/1", LeftScore, RightScore); end
      LeftWin = 1'b0; RightWin = 1'b0;
      repeat (6) @(negedge Clock);
      winRound(1'b0);
      checkCount++; if (LeftScore !== 3'd2) begin failCount++; $display("[TB] FAIL tie_single_after actual=%0d required=2", LeftScore); end
      checkCount++; if (dut.tiePtr !== 1'b0) begin failCount++; $display("[TB] FAIL tie_pointer_stable actual=%b required=0", dut.tiePtr); end
   endtask

   task automatic test_match_right();
      doReset();
      repeat (6) winRound(1'b1);
      checkCount++; if (RightScore !== 3'd6 || MatchOver !== 1'b0) begin failCount++; $display("[TB] FAIL match_six actual=%0d/%b required=6/0", RightScore, MatchOver); end
      RightWin = 1'b1;
      repeat (2) @(negedge Clock);
      checkCount++; if (RightScore !== 3'd7) begin failCount++; $display("[TB] FAIL match_score actual=%0d required=7", RightScore); end
      checkCount++; if (MatchOver !== 1'b1 || Victor !== 1'b1) begin failCount++; $display("[TB] FAIL match_victor actual=%b/%b required=1/1", MatchOver, Victor); end
      checkCount++; if (dut.state !== DONE) begin failCount++; $display("[TB] FAIL match_state actual=%0d required=%0d", dut.state, DONE); end
      RightWin = 1'b0;
      rrHigh = RoundReset ? 1 : 0;
      repeat (3) begin
         LeftWin = 1'b1;
         @(negedge Clock); if (RoundReset) rrHigh++;
         LeftWin = 1'b0; RightWin = 1'b1;
         @(negedge Clock); if (RoundReset) rrHigh++;
         RightWin = 1'b0;
         @(negedge Clock); if (RoundReset) rrHigh++;
      end
      checkCount++; if (rrHigh != 0) begin failCount++; $display("[TB] FAIL match_round_reset_quiet actual=%0d required=0", rrHigh); end
      checkCount++; if (LeftScore !== 3'd0 || RightScore !== 3'd7) begin failCount++; $display("[TB] FAIL match_frozen_scores actual=%0d/%0d required=0/7", LeftScore, RightScore); end
      checkCount++; if (MatchOver !== 1'b1 || Victor !== 1'b1) begin failCount++; $display("[TB] FAIL match_frozen_victor actual=%b/%b required=1/1", MatchOver, Victor); end
   endtask

   task automatic test_edge_during_restart();
      doReset();
      RightWin = 1'b1;
      repeat (2) @(negedge Clock);
      RightWin = 1'b0;
      @(negedge Clock);
      LeftWin = 1'b1;
      repeat (8) @(negedge Clock);
      checkCount++; if (LeftScore !== 3'd0 || RightScore !== 3'd1) begin failCount++; $display("[TB] FAIL restart_edge_dropped actual=%0d/%0d required=0/1", LeftScore, RightScore); end
      checkCount++; if (dut.state !== PLAY) begin failCount++; $display("[TB] FAIL restart_edge_state actual=%0d required=%0d", dut.state, PLAY); end
      LeftWin = 1'b0;
      @(negedge Clock);
   endtask

   task automatic test_reset_mid_restart();
      doReset();
      LeftWin = 1'b1; RightWin = 1'b1;
      @(negedge Clock);
      LeftWin = 1'b0; RightWin = 1'b0;
      repeat (6) @(negedge Clock);
      winRound(1'b0);
      LeftWin = 1'b1;
      repeat (2) @(negedge Clock);
      checkCount++; if (LeftScore !== 3'd3 || RoundReset !== 1'b1) begin failCount++; $display("[TB] FAIL midreset_setup actual=%0d/%b required=3/1", LeftScore, RoundReset); end
      @(negedge Clock);
      Reset = 1'b1; LeftWin = 1'b0;
      @(negedge Clock);
      checkCount++; if (LeftScore !== 3'd0 || RightScore !== 3'd0) begin failCount++; $display("[TB] FAIL midreset_scores actual=%0d/%0d required=0/0", LeftScore, RightScore); end
      checkCount++; if (RoundReset !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_round_reset actual=%b required=0", RoundReset); end
      checkCount++; if (dut.state !== PLAY) begin failCount++; $display("[TB] FAIL midreset_state actual=%0d required=%0d", dut.state, PLAY); end
      checkCount++; if (dut.tiePtr !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_tie_pointer actual=%b required=0", dut.tiePtr); end
      Reset = 1'b0;
      @(negedge Clock);
   endtask

   task automatic test_small_config();
      leftWinSmall = 1'b1;
      @(negedge Clock);
      rrHigh = roundResetSmall ? 1 : 0;
      checkCount++; if (matchOverSmall !== 1'b0) begin failCount++; $display("[TB] FAIL small_early_match actual=%b required=0", matchOverSmall); end
      @(negedge Clock);
      checkCount++; if (matchOverSmall !== 1'b1 || victorSmall !== 1'b0) begin failCount++; $display("[TB] FAIL small_victor actual=%b/%b required=1/0", matchOverSmall, victorSmall); end
      checkCount++; if (leftScoreSmall !== 3'd1) begin failCount++; $display("[TB] FAIL small_score actual=%0d required=1", leftScoreSmall); end
      leftWinSmall = 1'b0;
      repeat (5) begin
         if (roundResetSmall) rrHigh++;
         @(negedge Clock);
      end
      checkCount++; if (rrHigh != 0) begin failCount++; $display("[TB] FAIL small_round_reset actual=%0d required=0", rrHigh); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_single_left();
      test_tie();
      test_match_right();
      test_edge_during_restart();
      test_reset_mid_restart();
      test_small_config();
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/match_round_controller.md
Name: match_round_controller

Overview:
- Sequences a two-player round-based game.
- Detects round-win requests from the left and right playfield logic and arbitrates simultaneous wins with a round-robin tie-break.
- Increments the winner's score counter, pulses a playfield restart, and freezes on match victory.
- Sits between the per-round playfield logic (upstream) and the score/victor display drivers (downstream).

Parameters:
- SCORE_W, 3, width of each player score.
- WIN_SCORE, 7, score that ends the match; must be ≤ 2^SCORE_W − 1 and ≥ 1.
- HOLD_CYCLES, 4, length of the RoundReset pulse in clock cycles; ≥ 1.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- LeftWin  in  1  level from playfield; a rising edge requests a left round win.
- RightWin  in  1  level from playfield; a rising edge requests a right round win.
- LeftScore  out  SCORE_W  registered left player score.
- RightScore  out  SCORE_W  registered right player score.
- RoundReset  out  1  registered; high for HOLD_CYCLES cycles to restart the playfield.
- MatchOver  out  1  registered; high once either score reaches WIN_SCORE.
- Victor  out  1  registered; 0 = left, 1 = right; valid only while MatchOver = 1.

Behaviour:
- Reset (synchronous, sampled at posedge while high; overrides everything):
  - state = PLAY.
  - LeftScore = RightScore = 0; RoundReset = 0; MatchOver = 0; Victor = 0.
  - Edge-detect registers = 0; tie pointer = 0; hold counter = 0.
  - Reset in any state, including mid-RESTART or DONE, returns to these values on that same edge.
- Edge detection:
  - prevL and prevR register LeftWin and RightWin every cycle in every non-reset state.
  - reqL = LeftWin & ~prevL; reqR = RightWin & ~prevR.
  - An input held high produces exactly one request.
  - Edges arriving outside PLAY are consumed (prev still updates) and never deferred.
- FSM states: PLAY, AWARD, RESTART, DONE.
- PLAY:
  - reqL only → grant = left, go to AWARD.
  - reqR only → grant = right, go to AWARD.
  - reqL & reqR → grant = tie pointer (0 = left, 1 = right), toggle tie pointer, go to AWARD.
  - No request → stay in PLAY.
- AWARD (exactly one cycle):
  - Increment the granted score by 1.
  - If the new value equals WIN_SCORE: go to DONE; set MatchOver = 1 and Victor = grant on the same edge.
  - Otherwise: go to RESTART, load hold counter = HOLD_CYCLES − 1, set RoundReset = 1 on the same edge.
- RESTART:
  - RoundReset stays 1; hold counter decrements each cycle.
  - When the counter reads 0: clear RoundReset, go to PLAY.
  - RoundReset is high for exactly HOLD_CYCLES cycles.
- DONE:
  - Scores, MatchOver and Victor hold; RoundReset = 0; all requests ignored until Reset.
- Latency:
  - A rising edge first sampled at posedge k moves the FSM to AWARD at k.
  - The score updates at k+1; RoundReset is high from k+1 through k+HOLD_CYCLES.
  - PLAY resumes at k+HOLD_CYCLES+1.
- Width rules:
  - Scores are unsigned and never exceed WIN_SCORE, so no wrap is possible.
  - The increment is computed at SCORE_W+1 bits and compared against WIN_SCORE.
- Tie pointer changes only on a simultaneous request, never on single grants.

Decomposition:
- Shared package match_pkg:
  - State enumeration (PLAY = 0, AWARD = 1, RESTART = 2, DONE = 3).
  - Victor encoding constants (VICTOR_LEFT = 0, VICTOR_RIGHT = 1).
  - Default WIN_SCORE and SCORE_W.
- Sub-module player_score_counter, instantiated twice:
  - Ports: Clock, Reset, Inc, Score.
  - Synchronous active-high clear to 0; +1 when Inc is high.
  - The controller drives Inc only in AWARD for the granted side.

Test Plan:
- Reset, then pulse LeftWin 0→1 once and hold it high → LeftScore 0→1 one cycle after the FSM enters AWARD; RoundReset high for exactly 4 cycles; no second increment while held.
- LeftWin and RightWin rise on the same cycle, twice (separated by a full restart) → first tie awards left (LeftScore = 1), second awards right (RightScore = 1).
- Seven right wins with full restarts in between → RightScore = 7, MatchOver = 1, Victor = 1, RoundReset stays 0; further LeftWin/RightWin edges leave all outputs unchanged.
- LeftWin rises during RESTART (cycle 2 of 4) → no score change; LeftScore unchanged after returning to PLAY.
- Assert Reset during cycle 2 of RESTART with LeftScore = 3 → next edge: all scores 0, RoundReset 0, state PLAY, tie pointer 0.
- WIN_SCORE = 1, HOLD_CYCLES = 1 override; a single LeftWin edge → MatchOver = 1, Victor = 0, LeftScore = 1, and RoundReset is never asserted.
